// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- widths, round-header codes, FSM states and GF(2^8) helpers for the
// MixColumns stage; gf_mul9/11/13/14 exist only with AES_MIXCOL_INV_EN. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

   localparam int HEADER_W = 4;
   localparam int STATE_W  = 128;
   localparam int DATA_W   = HEADER_W + STATE_W;
   localparam int COL_W    = 32;

   localparam logic [HEADER_W-1:0] FINAL_ROUND = 4'hA;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MIX  = 1'b1
   } state_t;

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

`ifdef AES_MIXCOL_INV_EN
   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/mix_column.sv
// ---------------------------------------------------------------------------
// mix_column -- combinational MixColumns on one 32-bit column (s0 in MSB);
// inverse transform and inv select added with AES_MIXCOL_INV_EN. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mix_column
   import aes_pkg::*;
(
`ifdef AES_MIXCOL_INV_EN
   input  logic             inv,
`endif
   input  logic [COL_W-1:0] col_in,
   output logic [COL_W-1:0] col_out
);

   logic [7:0] s0, s1, s2, s3;
   logic [COL_W-1:0] fwd;

   assign {s0, s1, s2, s3} = col_in;

   assign fwd = {gf_mul2(s0) ^ gf_mul3(s1) ^ s2 ^ s3,
                 s0 ^ gf_mul2(s1) ^ gf_mul3(s2) ^ s3,
                 s0 ^ s1 ^ gf_mul2(s2) ^ gf_mul3(s3),
                 gf_mul3(s0) ^ s1 ^ s2 ^ gf_mul2(s3)};

`ifdef AES_MIXCOL_INV_EN
   logic [COL_W-1:0] rev;

   assign rev = {gf_mul14(s0) ^ gf_mul11(s1) ^ gf_mul13(s2) ^ gf_mul9(s3),
                 gf_mul9(s0) ^ gf_mul14(s1) ^ gf_mul11(s2) ^ gf_mul13(s3),
                 gf_mul13(s0) ^ gf_mul9(s1) ^ gf_mul14(s2) ^ gf_mul11(s3),
                 gf_mul11(s0) ^ gf_mul13(s1) ^ gf_mul9(s2) ^ gf_mul14(s3)};

   assign col_out = inv ? rev : fwd;
`else
   assign col_out = fwd;
`endif

endmodule

`default_nettype wire

// File: rtl/mix_columns_stage.sv
// ---------------------------------------------------------------------------
// mix_columns_stage -- 4-cycle column-serial MixColumns with final-round bypass;
// AES_MIXCOL_INV_EN adds the decrypt port and InvMixColumns. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mix_columns_stage
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              load,
`ifdef AES_MIXCOL_INV_EN
   input  logic              decrypt,
`endif
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              valid
);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [HEADER_W-1:0] hdr_q, hdr_d;
   logic [STATE_W-1:0]  work_q, work_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic [COL_W-1:0]    col_in, col_mixed, col_res;

`ifdef AES_MIXCOL_INV_EN
   logic inv_q, inv_d;

   mix_column u_mix_column (
      .inv     (inv_q),
      .col_in  (col_in),
      .col_out (col_mixed)
   );
`else
   mix_column u_mix_column (
      .col_in  (col_in),
      .col_out (col_mixed)
   );
`endif

   always_comb begin
      case (cnt_q)
         2'd0:    col_in = work_q[127:96];
         2'd1:    col_in = work_q[95:64];
         2'd2:    col_in = work_q[63:32];
         default: col_in = work_q[31:0];
      endcase
   end

   assign col_res = (hdr_q == FINAL_ROUND) ? col_in : col_mixed;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hdr_d      = hdr_q;
      work_d     = work_q;
      data_out_d = data_out_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
`ifdef AES_MIXCOL_INV_EN
      inv_d      = inv_q;
`endif
      if (state_q == MIX) begin
         // Each column is read once, so results overwrite the work slice in place.
         case (cnt_q)
            2'd0:    work_d[127:96] = col_res;
            2'd1:    work_d[95:64]  = col_res;
            2'd2:    work_d[63:32]  = col_res;
            default: work_d[31:0]   = col_res;
         endcase
         if (cnt_q == 2'd3) begin
            data_out_d = {hdr_q, work_d};
            valid_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
            cnt_d      = 2'd0;
         end else begin
            cnt_d = cnt_q + 2'd1;
         end
      end
      // A load on the final column edge still completes the old word first.
      if (load) begin
         hdr_d   = data_in[DATA_W-1:STATE_W];
         work_d  = data_in[STATE_W-1:0];
         cnt_d   = 2'd0;
         state_d = MIX;
         busy_d  = 1'b1;
`ifdef AES_MIXCOL_INV_EN
         inv_d   = decrypt;
`endif
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         hdr_q      <= '0;
         work_q     <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
`ifdef AES_MIXCOL_INV_EN
         inv_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hdr_q      <= hdr_d;
         work_q     <= work_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
`ifdef AES_MIXCOL_INV_EN
         inv_q      <= inv_d;
`endif
      end
   end

   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign valid    = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_stage.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_stage -- directed FIPS-197 column vectors against hand-computed
// MixColumns results; inverse vectors only with AES_MIXCOL_INV_EN. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mix_columns_stage;

   logic         clk;
   logic         n_rst;
   logic         load;
   logic [131:0] data_in;
   logic [131:0] data_out;
   logic         busy;
   logic         valid;
`ifdef AES_MIXCOL_INV_EN
   logic         decrypt;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] cin  [5];
   logic [31:0] cout [5];

   mix_columns_stage dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (load),
`ifdef AES_MIXCOL_INV_EN
      .decrypt  (decrypt),
`endif
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rep4(input logic [31:0] c);
      return {c, c, c, c};
   endfunction

   // Load at edge E, then check busy/valid at E+1..E+5 and data at E+4.
   task automatic run_word(input string tag, input logic [3:0] hdr,
                           input logic [127:0] st, input logic [127:0] exp);
      load    = 1'b1;
      data_in = {hdr, st};
      @(negedge clk);
      load = 1'b0;
      check({tag, " busy@E"}, {130'd0, busy, valid}, {130'd0, 2'b10});
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check({tag, " busy@mid"}, {130'd0, busy, valid}, {130'd0, 2'b10});
      end
      @(negedge clk);
      check({tag, " flags@E+4"}, {130'd0, busy, valid}, {130'd0, 2'b01});
      check({tag, " data@E+4"}, data_out, {hdr, exp});
      @(negedge clk);
      check({tag, " flags@E+5"}, {130'd0, busy, valid}, {130'd0, 2'b00});
      check({tag, " hold@E+5"}, data_out, {hdr, exp});
   endtask

   initial begin
      logic [3:0] h;
      cin[0] = 32'hd4bf5d30; cout[0] = 32'h046681e5;
      cin[1] = 32'hdb135345; cout[1] = 32'h8e4da1bc;
      cin[2] = 32'hf20a225c; cout[2] = 32'h9fdc589d;
      cin[3] = 32'h01010101; cout[3] = 32'h01010101;
      cin[4] = 32'hc6c6c6c6; cout[4] = 32'hc6c6c6c6;

      n_rst   = 1'b0;
      load    = 1'b0;
      data_in = '0;
`ifdef AES_MIXCOL_INV_EN
      decrypt = 1'b0;
`endif
      @(negedge clk);
      check("reset data", data_out, 132'd0);
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle outputs", {data_out[129:0], busy, valid}, 132'd0);
      end

      // FIPS-197 round-1 columns, each replicated four times
      for (int i = 0; i < 5; i++)
         run_word("fwd column", 4'h1, rep4(cin[i]), rep4(cout[i]));

      // Distinct columns to pin down column-to-slice ordering
      run_word("mixed columns", 4'h3,
               {cin[0], cin[1], cin[2], cin[4]},
               {cout[0], cout[1], cout[2], cout[4]});

      run_word("final bypass", 4'hA,
               128'h0123456789abcdeffedcba9876543210,
               128'h0123456789abcdeffedcba9876543210);

      // Abort: second load at E+2 replaces the first word
      load    = 1'b1;
      data_in = {4'h5, rep4(cin[0])};
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      load    = 1'b1;
      data_in = {4'h2, rep4(cin[1])};
      @(negedge clk);
      load = 1'b0;
      check("abort no valid E+2", {131'd0, valid}, 132'd0);
      for (int k = 3; k < 6; k++) begin
         @(negedge clk);
         check("abort no valid", {131'd0, valid}, 132'd0);
      end
      @(negedge clk);
      check("abort valid E+6", {131'd0, valid}, 132'd1);
      check("abort data E+6", data_out, {4'h2, rep4(cout[1])});
      @(negedge clk);
      check("abort single valid", {131'd0, valid}, 132'd0);

      // Back-to-back: a load every 4 cycles for 8 words
      for (int c = 0; c < 34; c++) begin
         if ((c % 4 == 0) && (c / 4 < 8)) begin
            h       = 4'(c / 4 + 1);
            load    = 1'b1;
            data_in = {h, rep4(cin[(c / 4) % 5])};
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
         if ((c >= 4) && (c % 4 == 0) && (c / 4 <= 8)) begin
            h = 4'(c / 4);
            check("b2b valid", {131'd0, valid}, 132'd1);
            check("b2b data", data_out, {h, rep4(cout[(c / 4 - 1) % 5])});
         end else begin
            check("b2b no valid", {131'd0, valid}, 132'd0);
         end
      end

      // Reset dropped mid-pass at E+2
      load    = 1'b1;
      data_in = {4'h4, rep4(cin[2])};
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      #3 n_rst = 1'b0;
      #1 check("reset mid-pass", {data_out[129:0], busy, valid}, 132'd0);
      check("reset mid-pass hdr", {130'd0, data_out[131:130]}, 132'd0);
      @(negedge clk);
      n_rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post-reset quiet", {data_out[129:0], busy, valid}, 132'd0);
      end

`ifdef AES_MIXCOL_INV_EN
      decrypt = 1'b1;
      run_word("inv column", 4'h6, rep4(32'h8e4da1bc), rep4(32'hdb135345));
      run_word("inv bypass", 4'hA, rep4(32'h8e4da1bc), rep4(32'h8e4da1bc));
      decrypt = 1'b0;
      run_word("fwd after inv", 4'h6, rep4(cin[0]), rep4(cout[0]));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
